// File: rtl/hex_button_counter.sv
// hex_button_counter: two raw push-buttons -> synchronized, debounced,
// edge-detected events -> 4-bit wrapping up/down count for the 7-seg decoder.

// Per-button lane: 2-flop synchronizer, debounce counter, rising-edge detect.
module hex_button_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic             stable, stable_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchronizer; only sync2 is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Stable level flips only after DEBOUNCE_CYCLES consecutive differing
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed copy for edge detection; releases produce nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d <= 1'b0;
    else        stable_d <= stable;
  end

  assign press = stable & ~stable_d;
endmodule

// Top: two debounce lanes feeding the registered count.
module hex_button_counter #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_up,
  input  logic       i_btn_dn,
  input  logic       i_clear,
  output logic [3:0] o_binary_num,
  output logic       o_changed
);
  localparam int NUM_BTNS = 2;  // lane 0 = up, lane 1 = down

  logic [NUM_BTNS-1:0] btn;
  logic [NUM_BTNS-1:0] press;
  logic                press_up, press_dn;

  assign btn      = {i_btn_dn, i_btn_up};
  assign press_up = press[0];
  assign press_dn = press[1];

  hex_button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db [NUM_BTNS-1:0] (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .btn  (btn),
    .press(press)
  );

  // Count update: clear wins, simultaneous presses cancel, else step with wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_binary_num <= 4'h0;
      o_changed    <= 1'b0;
    end else begin
      o_changed <= 1'b0;
      if (i_clear) begin
        o_binary_num <= 4'h0;
        o_changed    <= (o_binary_num != 4'h0);
      end else if (press_up && press_dn) begin
        o_binary_num <= o_binary_num;
      end else if (press_up) begin
        o_binary_num <= o_binary_num + 4'd1;
        o_changed    <= 1'b1;
      end else if (press_dn) begin
        o_binary_num <= o_binary_num - 4'd1;
        o_changed    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hex_button_counter.sv
// Directed bench for hex_button_counter with DEBOUNCE_CYCLES = 4.
module tb_hex_button_counter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_dn, clear;
  logic [3:0] binary_num;
  logic       changed;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  hex_button_counter #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_btn_up    (btn_up),
    .i_btn_dn    (btn_dn),
    .i_clear     (clear),
    .o_binary_num(binary_num),
    .o_changed   (changed)
  );

  always #5 clk = ~clk;

  // Count o_changed pulses, sampled mid-cycle.
  always @(negedge clk) if (changed === 1'b1) pulses++;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean press and release of one (or both) buttons.
  task automatic press_btn(input bit up, input bit dn);
    btn_up = up;
    btn_dn = dn;
    tick(8);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick(8);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_single_press();
    btn_up = 1'b0; btn_dn = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    #3;
    vectors++;
    if (binary_num !== 4'h0 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got num=%h chg=%b, want num=0 chg=0", binary_num, changed);
    end
    tick(2);
    rst_n  = 1'b1;
    btn_up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      vectors++;
      if (binary_num !== ((k >= 7) ? 4'h1 : 4'h0) || changed !== (k == 7)) begin
        miscompares++;
        $display("FAIL single_press edge %0d: got num=%h chg=%b, want num=%h chg=%b",
                 k, binary_num, changed, (k >= 7) ? 4'h1 : 4'h0, k == 7);
      end
    end
    tick(10);
    vectors++;
    if (binary_num !== 4'h1) begin
      miscompares++;
      $display("FAIL held_no_repeat: got num=%h, want 1", binary_num);
    end
    btn_up = 1'b0;
    tick(8);
    vectors++;
    if (binary_num !== 4'h1) begin
      miscompares++;
      $display("FAIL release_no_event: got num=%h, want 1", binary_num);
    end
  endtask

  task automatic test_glitch();
    int p0;
    do_reset();
    p0 = pulses;
    for (int r = 0; r < 5; r++) begin
      btn_up = 1'b1; tick(3);
      btn_up = 1'b0; tick(2);
    end
    tick(10);
    vectors++;
    if (binary_num !== 4'h0 || pulses != p0) begin
      miscompares++;
      $display("FAIL glitch: got num=%h pulses=%0d, want num=0 pulses=0", binary_num, pulses - p0);
    end
  endtask

  task automatic test_wrap();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      press_btn(1'b1, 1'b0);
      vectors++;
      if (binary_num !== 4'((i + 1) % 16)) begin
        miscompares++;
        $display("FAIL wrap_up step %0d: got num=%h, want %h", i, binary_num, 4'((i + 1) % 16));
      end
    end
    vectors++;
    if (pulses - p0 != 16) begin
      miscompares++;
      $display("FAIL wrap_pulses: got %0d, want 16", pulses - p0);
    end
    press_btn(1'b0, 1'b1);
    vectors++;
    if (binary_num !== 4'hF) begin
      miscompares++;
      $display("FAIL wrap_down: got num=%h, want f", binary_num);
    end
  endtask

  task automatic test_simultaneous();
    int p0;
    do_reset();
    for (int i = 0; i < 5; i++) press_btn(1'b1, 1'b0);
    vectors++;
    if (binary_num !== 4'h5) begin
      miscompares++;
      $display("FAIL simul_setup: got num=%h, want 5", binary_num);
    end
    p0 = pulses;
    press_btn(1'b1, 1'b1);
    vectors++;
    if (binary_num !== 4'h5 || pulses != p0) begin
      miscompares++;
      $display("FAIL simul_both: got num=%h pulses=%0d, want num=5 pulses=0", binary_num, pulses - p0);
    end
    press_btn(1'b0, 1'b1);
    vectors++;
    if (binary_num !== 4'h4) begin
      miscompares++;
      $display("FAIL simul_then_dn: got num=%h, want 4", binary_num);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) press_btn(1'b1, 1'b0);
    vectors++;
    if (binary_num !== 4'h9) begin
      miscompares++;
      $display("FAIL clear_setup: got num=%h, want 9", binary_num);
    end
    // Debounced press is live between edge 6 and edge 7; clear lands on edge 7.
    btn_up = 1'b1;
    tick(6);
    clear = 1'b1;
    tick(1);
    vectors++;
    if (binary_num !== 4'h0 || changed !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_with_press: got num=%h chg=%b, want num=0 chg=1", binary_num, changed);
    end
    clear = 1'b0;
    tick(4);
    btn_up = 1'b0;
    tick(8);
    vectors++;
    if (binary_num !== 4'h0) begin
      miscompares++;
      $display("FAIL clear_press_discarded: got num=%h, want 0", binary_num);
    end
    clear = 1'b1;
    tick(1);
    vectors++;
    if (binary_num !== 4'h0 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_at_zero: got num=%h chg=%b, want num=0 chg=0", binary_num, changed);
    end
    clear = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_mid_debounce();
    press_btn(1'b1, 1'b0);
    vectors++;
    if (binary_num !== 4'h1) begin
      miscompares++;
      $display("FAIL rst_mid_setup: got num=%h, want 1", binary_num);
    end
    btn_dn = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (binary_num !== 4'h0 || changed !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got num=%h chg=%b, want num=0 chg=0", binary_num, changed);
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      vectors++;
      if (binary_num !== ((k >= 7) ? 4'hF : 4'h0) || changed !== (k == 7)) begin
        miscompares++;
        $display("FAIL rst_mid_requalify edge %0d: got num=%h chg=%b, want num=%h chg=%b",
                 k, binary_num, changed, (k >= 7) ? 4'hF : 4'h0, k == 7);
      end
    end
    btn_dn = 1'b0;
    tick(8);
  endtask

  initial begin
    test_reset_single_press();
    test_glitch();
    test_wrap();
    test_simultaneous();
    test_clear();
    test_reset_mid_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
